blake2_core_arbiter: RTL
========================

Name: blake2_core_arbiter

Overview:
Shares one Blake2 hash core between NUM_REQ block-level requesters, each presenting complete 1024-bit blocks with message flags. Grants the core round-robin per message, not per block, because the core holds chaining state from first block to final. Translates each block's first/last flags into core init/next/final pulses, waits on core ready/digest, and returns the digest to the owning requester. Sits between the per-source block assemblers and the single hash core.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
BLOCK_WIDTH, 1024, core block width in bits
DIGEST_WIDTH, 512, core digest width in bits
LEN_WIDTH, 128, byte-count width passed to core

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester block valid
req_first  in  NUM_REQ  block is first of its message
req_last  in  NUM_REQ  block is last of its message
req_block  in  NUM_REQ*BLOCK_WIDTH  flattened blocks, requester i at [i*BLOCK_WIDTH+:BLOCK_WIDTH]
req_length  in  NUM_REQ*LEN_WIDTH  cumulative message bytes including this block
req_ready  out  NUM_REQ  one-cycle accept pulse to owner
rsp_valid  out  NUM_REQ  one-cycle digest-valid pulse to owner
rsp_digest  out  DIGEST_WIDTH  digest, valid with rsp_valid
core_init, core_next, core_final  out  1 each  command pulses
core_block  out  BLOCK_WIDTH  registered block to core
core_length  out  LEN_WIDTH  registered length to core
core_ready  in  1  core idle/accepting
core_digest_valid  in  1  core digest valid
core_digest  in  DIGEST_WIDTH  core digest
busy  out  1  a message is locked
owner  out  $clog2(NUM_REQ)  current/last owner index

Behaviour:
- Reset: all outputs 0; FSM IDLE; owner=0; rr pointer=NUM_REQ-1 so requester 0 wins first.
- States: IDLE, SELECT, ISSUE, SETTLE, WAIT_READY, WAIT_DIGEST, HOLD.
- IDLE: candidates are requesters with req_valid&req_first. Round-robin from rr pointer+1 with wrap. On a hit, latch owner, block and length into core_block/core_length; set busy=1; go to SELECT. Valid blocks without req_first are never granted in IDLE.
- SELECT: one-cycle register stage; go to ISSUE.
- ISSUE: wait for core_ready=1. Then, for exactly one cycle, pulse the command and req_ready[owner]:
  - first&!last: core_init.
  - !first&!last: core_next.
  - !first&last: core_final.
  - first&last: core_init and core_final together.
  - Flags used are those latched at capture.
- Next state after ISSUE is SETTLE, then WAIT_READY. SETTLE ignores core_ready for the one cycle after a command, because the core drops ready one cycle late.
- WAIT_READY: on core_ready=1, go to WAIT_DIGEST if the block was last, otherwise HOLD.
- HOLD: lock held; only the owner is eligible; other requesters see req_ready=0.
  - owner req_valid & !req_first: capture the block and go to SELECT.
  - owner req_valid & req_first: not accepted; stays in HOLD.
- WAIT_DIGEST: on core_digest_valid, register core_digest into rsp_digest and pulse rsp_valid[owner] one cycle. Set rr pointer=owner, busy=0, go to IDLE. The next grant can start the following cycle.
- Latency, single-block message (core ready throughout): capture to command = 2 cycles; digest to rsp_valid = 1 cycle.
- Simultaneous events:
  - Multiple first-valid requesters in IDLE: exactly one is granted.
  - core_digest_valid while not in WAIT_DIGEST: ignored.
- Reset mid-operation: immediate return to reset state, lock dropped. The core must be reset alongside.
- req_ready is never asserted without the matching command pulse in the same cycle.

Optional Feature:
BLAKE2_ARB_ERR_EN.
- Defined: adds output err_protocol (1 bit, sticky until reset). Set on any of:
  - non-first block valid in IDLE for 16 consecutive cycles;
  - owner presents req_first while in HOLD;
  - core_digest_valid outside WAIT_DIGEST.
  - Functional behaviour is otherwise unchanged.
- Undefined: port absent, no checking logic.

Test Plan:
- Single-block message, req 0 (first=last=1, length=64), core_ready=1 → init and final pulse together 2 cycles after capture; req_ready[0] in the same cycle; core_length=64; rsp_valid[0] 1 cycle after core_digest_valid, with rsp_digest = core_digest.
- Three-block message, req 1 (lengths 128, 256, 300) → command sequence init, next, final; core_length 128, 256, 300; busy=1 from first capture to rsp_valid.
- Both requesters hold first blocks from reset → req 0 granted first. After its digest, req 1 is granted with no intervening idle beyond IDLE. req 1's block is never accepted while req 0 holds the lock.
- Owner in HOLD, core_ready held low 10 cycles after a next command → no req_ready to anyone until core_ready returns. The next block is then issued.
- reset_n asserted in WAIT_DIGEST → all outputs 0 asynchronously; after release, req 1 with first block is granted normally.
- BLAKE2_ARB_ERR_EN defined, owner asserts req_first in HOLD → err_protocol=1 and stays 1; block not accepted.

Source files
------------

// File: rtl/blake2_core_arbiter.sv
// Per-message round-robin arbiter sharing one Blake2 core between NUM_REQ block sources.
// Optional protocol-error flag (err_protocol) is built when BLAKE2_ARB_ERR_EN is defined.
`timescale 1ns/1ps

module blake2_core_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int BLOCK_WIDTH  = 1024,
    parameter int DIGEST_WIDTH = 512,
    parameter int LEN_WIDTH    = 128
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_first,
    input  logic [NUM_REQ-1:0]              req_last,
    input  logic [NUM_REQ*BLOCK_WIDTH-1:0]  req_block,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_length,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DIGEST_WIDTH-1:0]         rsp_digest,
    output logic                            core_init,
    output logic                            core_next,
    output logic                            core_final,
    output logic [BLOCK_WIDTH-1:0]          core_block,
    output logic [LEN_WIDTH-1:0]            core_length,
    input  logic                            core_ready,
    input  logic                            core_digest_valid,
    input  logic [DIGEST_WIDTH-1:0]         core_digest,
    output logic                            busy,
    output logic [$clog2(NUM_REQ)-1:0]      owner
`ifdef BLAKE2_ARB_ERR_EN
    ,
    output logic                            err_protocol
`endif
);

    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SELECT      = 3'd1,
        ST_ISSUE       = 3'd2,
        ST_SETTLE      = 3'd3,
        ST_WAIT_READY  = 3'd4,
        ST_WAIT_DIGEST = 3'd5,
        ST_HOLD        = 3'd6
    } state_t;

    state_t               state_r;
    logic [OW-1:0]        rr_ptr_r;
    logic                 first_r;
    logic                 last_r;

    logic [NUM_REQ-1:0]   cand_s;
    logic                 grant_found_s;
    logic [OW-1:0]        grant_idx_s;
    logic [OW-1:0]        sel_idx_s;
    logic [BLOCK_WIDTH-1:0] sel_block_s;
    logic [LEN_WIDTH-1:0] sel_length_s;
    logic                 owner_valid_s;
    logic                 owner_first_s;
    logic                 owner_last_s;

    // Round-robin pick among message starts; scanning farthest-first lets the nearest hit win.
    always_comb begin
        cand_s        = req_valid & req_first;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (cand_s[(int'(rr_ptr_r) + k) % NUM_REQ]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = OW'((int'(rr_ptr_r) + k) % NUM_REQ);
            end else begin
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // Capture source: the new winner while idle, otherwise the locked owner.
    always_comb begin
        sel_idx_s     = (state_r == ST_IDLE) ? grant_idx_s : owner;
        sel_block_s   = req_block[int'(sel_idx_s)*BLOCK_WIDTH +: BLOCK_WIDTH];
        sel_length_s  = req_length[int'(sel_idx_s)*LEN_WIDTH +: LEN_WIDTH];
        owner_valid_s = req_valid[owner];
        owner_first_s = req_first[owner];
        owner_last_s  = req_last[owner];
    end

    // Message-lock FSM with registered command, handshake and digest outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= OW'(NUM_REQ - 1);
            owner       <= '0;
            busy        <= 1'b0;
            first_r     <= 1'b0;
            last_r      <= 1'b0;
            core_block  <= '0;
            core_length <= '0;
            core_init   <= 1'b0;
            core_next   <= 1'b0;
            core_final  <= 1'b0;
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_digest  <= '0;
        end else begin
            core_init  <= 1'b0;
            core_next  <= 1'b0;
            core_final <= 1'b0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        owner       <= grant_idx_s;
                        core_block  <= sel_block_s;
                        core_length <= sel_length_s;
                        first_r     <= 1'b1;
                        last_r      <= req_last[grant_idx_s];
                        busy        <= 1'b1;
                        state_r     <= ST_SELECT;
                    end
                end
                ST_SELECT: state_r <= ST_ISSUE;
                ST_ISSUE: begin
                    if (core_ready) begin
                        core_init        <= first_r;
                        core_final       <= last_r;
                        core_next        <= !first_r && !last_r;
                        req_ready[owner] <= 1'b1;
                        state_r          <= ST_SETTLE;
                    end
                end
                // The core drops ready one cycle after a command, so skip that cycle.
                ST_SETTLE: state_r <= ST_WAIT_READY;
                ST_WAIT_READY: begin
                    if (core_ready) begin
                        state_r <= last_r ? ST_WAIT_DIGEST : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (owner_valid_s && !owner_first_s) begin
                        core_block  <= sel_block_s;
                        core_length <= sel_length_s;
                        first_r     <= 1'b0;
                        last_r      <= owner_last_s;
                        state_r     <= ST_SELECT;
                    end
                end
                ST_WAIT_DIGEST: begin
                    if (core_digest_valid) begin
                        rsp_digest       <= core_digest;
                        rsp_valid[owner] <= 1'b1;
                        rr_ptr_r         <= owner;
                        busy             <= 1'b0;
                        state_r          <= ST_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BLAKE2_ARB_ERR_EN
    logic [3:0] orphan_cnt_r;
    logic       orphan_s;

    // A non-first block waiting while idle can never be granted.
    always_comb begin
        orphan_s = (state_r == ST_IDLE) && (|(req_valid & ~req_first));
    end

    // Sticky protocol-violation flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            orphan_cnt_r <= 4'd0;
            err_protocol <= 1'b0;
        end else begin
            if (orphan_s) begin
                orphan_cnt_r <= (orphan_cnt_r == 4'd15) ? orphan_cnt_r : orphan_cnt_r + 4'd1;
            end else begin
                orphan_cnt_r <= 4'd0;
            end
            if ((orphan_s && orphan_cnt_r == 4'd15) ||
                (state_r == ST_HOLD && owner_valid_s && owner_first_s) ||
                (core_digest_valid && state_r != ST_WAIT_DIGEST)) begin
                err_protocol <= 1'b1;
            end
        end
    end
`endif

endmodule
